data_ram: RTL and testbench

- Single-port, word-addressed data memory for the ARMv4 single-cycle processor (Flappy Bird system); sits on the CPU data bus.
- Writes are synchronous on the rising clock edge; reads are combinational (asynchronous).
- Asynchronous active-high reset clears the entire array to zero.

---
 rtl/data_ram.sv | 46 ++++
 tb/tb_data_ram.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Word-addressed data memory on the CPU data bus: synchronous write, combinational read.
// Latency: read 0 cycles (address to data_output), write lands on the next rising clk edge.
// Backpressure: none, always ready; out-of-range or unknown addresses read 0 and never write.
module data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic [DATA_WIDTH-1:0] data_output
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  addr_ok;
    logic [IDX_W-1:0]      idx;

    // Full-width compare so upper address bits can never alias onto a real word.
    assign addr_ok = (address < DEPTH_A);
    assign idx     = address[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable && addr_ok) begin
            mem[idx] <= data_input;
        end
    end

    // An unknown address makes the if-condition false, so the bus reads 0.
    always_comb begin
        data_output = '0;
        if (!rst && addr_ok) begin
            data_output = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: expected read values are queued as stimulus is driven
// and popped when data_output is sampled.
module tb_data_ram;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_input = '0;
    logic [DW-1:0] data_output;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    int            checks = 0;
    int            errors = 0;

    data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .address      (address),
        .data_input   (data_input),
        .data_output  (data_output)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        rst = 1'b1;
        address = 'z;
        write_enable = 1'b0;
        exp_q.push_back('0);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL reset_hold: got %h want %h", got, want);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            address = AW'(i);
            exp_q.push_back('0);
            #1;
            got = data_output; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL reset_word%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        write_enable = 1'b1; address = 1; data_input = 32'h0000FA32;
        @(negedge clk);
        write_enable = 1'b0; data_input = 32'h0000EA99;
        @(negedge clk);
        exp_q.push_back(32'h0000FA32);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL basic_word1: got %h want %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] exps  [3];
        addrs = '{5, 3, 1};
        exps  = '{32'h0000EA99, 32'h0000EA99, 32'h0000FA32};
        @(negedge clk);
        write_enable = 1'b1; address = 5; data_input = 32'h0000EA99;
        @(negedge clk);
        address = 3;
        @(negedge clk);
        write_enable = 1'b0; data_input = 32'h11111111;
        // All three reads happen inside one low clock phase: no edge between them.
        for (int i = 0; i < 3; i++) begin
            address = addrs[i];
            exp_q.push_back(exps[i]);
            #1;
            got = data_output; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL multi_addr%0d: got %h want %h", addrs[i], got, want);
            end
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        address = 7; write_enable = 1'b1; data_input = 32'h12345678;
        exp_q.push_back('0);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL rdw_before: got %h want %h", got, want);
        end
        exp_q.push_back(32'h12345678);
        @(posedge clk);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL rdw_after: got %h want %h", got, want);
        end
        write_enable = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] exps  [4];
        addrs = '{64, 32'h80000001, 0, 1};
        exps  = '{32'h0, 32'h0, 32'h0, 32'h0000FA32};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            address = addrs[i]; write_enable = 1'b1; data_input = 32'hDEADBEEF;
        end
        @(negedge clk);
        write_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = addrs[i];
            exp_q.push_back(exps[i]);
            #1;
            got = data_output; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL oor_addr%h: got %h want %h", addrs[i], got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] addrs [4];
        addrs = '{1, 3, 5, 7};
        @(negedge clk);
        address = 5;
        #2;
        rst = 1'b1;
        exp_q.push_back('0);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL arst_immediate: got %h want %h", got, want);
        end
        // Write attempt on an edge while reset is held must be discarded.
        write_enable = 1'b1; data_input = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        write_enable = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = addrs[i];
            exp_q.push_back('0);
            #1;
            got = data_output; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL arst_word%0d: got %h want %h", addrs[i], got, want);
            end
        end
        // Memory must accept writes again once reset is released.
        @(negedge clk);
        address = 2; write_enable = 1'b1; data_input = 32'hA5A5_0F0F;
        @(negedge clk);
        write_enable = 1'b0;
        exp_q.push_back(32'hA5A5_0F0F);
        #1;
        got = data_output; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL post_reset_write: got %h want %h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_read_during_write();
        test_out_of_range();
        test_async_reset();
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
